data_mem_bus_if: RTL and testbench

- Sequential bridge directly downstream of the load/store byte-lane controller.
- Takes its per-access store byte enables, aligned store data and the byte address, and runs a valid/ready request plus response transaction on the external data-memory bus.
- Returns the raw 32-bit read word to the load-extraction path and stalls the single-cycle core until the access completes.
- Includes a response timeout that reports a bus error.

---
 rtl/data_mem_bus_if.sv | 118 +++++++++++
 tb/tb_data_mem_bus_if.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus_if.sv
// Bridge between the load/store byte-lane controller and a valid/ready data-memory bus.
// Stalls the core for the length of each access and aborts with a bus error on response timeout.
module data_mem_bus_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Mem_Addr,
  input  logic        Load_Req,
  input  logic [3:0]  Data_Mem_Write_Ctrl,
  input  logic [31:0] Data_Mem_Write_Out,
  output logic [31:0] Data_Mem_Read,
  output logic        Mem_Stall,
  output logic        Mem_Error,
  output logic        Bus_Valid,
  input  logic        Bus_Ready,
  output logic [29:0] Bus_Addr,
  output logic        Bus_Write,
  output logic [3:0]  Bus_Byte_En,
  output logic [31:0] Bus_Wdata,
  input  logic        Bus_Resp_Valid,
  input  logic [31:0] Bus_Rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] COUNT_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] COUNT_MAX = '1;

  state_t               state_reg, state_next;
  logic [TIMEOUT_W-1:0] count_reg;
  logic [31:0]          read_reg;
  logic [29:0]          addr_reg;
  logic                 write_reg;
  logic [3:0]           byte_en_reg;
  logic [31:0]          wdata_reg;
  logic                 error_reg;

  logic is_store, req, start, busy, resp_done, abort;

  // Word address only; the byte offset is already folded into the byte enables.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Mem_Addr[1:0];

  assign is_store  = |Data_Mem_Write_Ctrl;
  assign req       = Load_Req | is_store;
  assign start     = (state_reg == IDLE) && req;
  assign busy      = (state_reg == REQ) || (state_reg == WAIT);
  assign resp_done = (state_reg == WAIT) && Bus_Resp_Valid;
  // A response landing on the final allowed cycle still completes normally.
  assign abort     = TIMEOUT_EN && busy && (count_reg == COUNT_LAST) && !resp_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req) state_next = REQ;
      REQ: begin
        if (abort)          state_next = DONE;
        else if (Bus_Ready) state_next = WAIT;
      end
      WAIT: if (resp_done || abort) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Bus_Valid = (state_reg == REQ);
    Mem_Stall = start || busy;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_reg   <= '0;
      read_reg    <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      byte_en_reg <= '0;
      wdata_reg   <= '0;
      error_reg   <= 1'b0;
    end else begin
      error_reg <= abort;
      if (start) begin
        addr_reg    <= Mem_Addr[31:2];
        write_reg   <= is_store;
        byte_en_reg <= is_store ? Data_Mem_Write_Ctrl : 4'hF;
        wdata_reg   <= is_store ? Data_Mem_Write_Out : 32'h0;
        count_reg   <= '0;
      end else if (busy && TIMEOUT_EN && (count_reg != COUNT_MAX)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (resp_done && !write_reg) begin
        read_reg <= Bus_Rdata;
      end else if (abort && !write_reg) begin
        read_reg <= 32'h0;
      end
    end
  end

  assign Data_Mem_Read = read_reg;
  assign Bus_Addr      = addr_reg;
  assign Bus_Write     = write_reg;
  assign Bus_Byte_En   = byte_en_reg;
  assign Bus_Wdata     = wdata_reg;
  assign Mem_Error     = error_reg;

endmodule

// File: tb/tb_data_mem_bus_if.sv
// Randomized self-checking bench for data_mem_bus_if with a reactive bus responder
// and a transaction-level expectation model (latency, timeout, read-word history).
module tb_data_mem_bus_if;
  localparam int T = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Mem_Addr;
  logic        Load_Req;
  logic [3:0]  Data_Mem_Write_Ctrl;
  logic [31:0] Data_Mem_Write_Out;
  logic [31:0] Data_Mem_Read;
  logic        Mem_Stall;
  logic        Mem_Error;
  logic        Bus_Valid;
  logic        Bus_Ready;
  logic [29:0] Bus_Addr;
  logic        Bus_Write;
  logic [3:0]  Bus_Byte_En;
  logic [31:0] Bus_Wdata;
  logic        Bus_Resp_Valid;
  logic [31:0] Bus_Rdata;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_txn = 0;
  logic [31:0] model_read;

  always #5 Clk = ~Clk;

  data_mem_bus_if #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_Addr(Mem_Addr), .Load_Req(Load_Req),
    .Data_Mem_Write_Ctrl(Data_Mem_Write_Ctrl), .Data_Mem_Write_Out(Data_Mem_Write_Out),
    .Data_Mem_Read(Data_Mem_Read), .Mem_Stall(Mem_Stall), .Mem_Error(Mem_Error),
    .Bus_Valid(Bus_Valid), .Bus_Ready(Bus_Ready), .Bus_Addr(Bus_Addr),
    .Bus_Write(Bus_Write), .Bus_Byte_En(Bus_Byte_En), .Bus_Wdata(Bus_Wdata),
    .Bus_Resp_Valid(Bus_Resp_Valid), .Bus_Rdata(Bus_Rdata)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access: the responder raises Ready on the (rdel+1)-th valid cycle and
  // the response on the (sdel+1)-th wait cycle; the DUT must abort once REQ+WAIT
  // would need more than T cycles.
  task automatic do_access(input bit ld, input logic [3:0] wctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input int rdel, input int sdel,
                           input logic [31:0] rdata);
    bit          st, tmo, done;
    int          r, w, n_stall, n_valid, n_wait, n_acc, n_err;
    logic [31:0] exp_read, exp_wd;
    logic [3:0]  exp_be;
    st = (wctrl != 4'h0);
    r = rdel + 1;
    w = sdel + 1;
    tmo = (r + w) > T;
    exp_be = st ? wctrl : 4'hF;
    exp_wd = st ? wdata : 32'h0;
    exp_read = st ? model_read : (tmo ? 32'h0 : rdata);
    n_stall = 0; n_valid = 0; n_wait = 0; n_acc = 0; n_err = 0; done = 0;
    @(negedge Clk);
    Load_Req = ld;
    Data_Mem_Write_Ctrl = wctrl;
    Mem_Addr = addr;
    Data_Mem_Write_Out = wdata;
    Bus_Ready = 1'b0;
    Bus_Resp_Valid = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (Mem_Error) n_err++;
      if (cyc == 0) check_val("idle_stall", Mem_Stall, 1'b1);
      if (!Mem_Stall && cyc > 0) begin
        done = 1;
        check_val("stall_cycles", n_stall, 1 + (tmo ? T : r + w));
        check_val("done_error", Mem_Error, tmo);
        check_val("done_read", Data_Mem_Read, exp_read);
        check_val("done_valid", Bus_Valid, 1'b0);
        Bus_Ready = 1'b0;
        Bus_Resp_Valid = 1'($urandom_range(0, 1));
        Bus_Rdata = $urandom;
      end else begin
        n_stall++;
        if (Bus_Valid) begin
          n_valid++;
          check_val("req_addr", Bus_Addr, addr[31:2]);
          check_val("req_write", Bus_Write, st);
          check_val("req_be", Bus_Byte_En, exp_be);
          check_val("req_wdata", Bus_Wdata, exp_wd);
          Bus_Ready = (n_valid == r);
          if (Bus_Ready) n_acc++;
          Bus_Resp_Valid = 1'($urandom_range(0, 1));
          Bus_Rdata = $urandom;
        end else if (n_acc > 0) begin
          n_wait++;
          Bus_Ready = 1'b0;
          Bus_Resp_Valid = (n_wait == w);
          Bus_Rdata = (n_wait == w) ? rdata : $urandom;
        end else begin
          Bus_Ready = 1'b0;
          Bus_Resp_Valid = 1'($urandom_range(0, 1));
          Bus_Rdata = $urandom;
        end
        if (cyc > 0) begin
          Mem_Addr = $urandom;
          Data_Mem_Write_Out = $urandom;
        end
        @(negedge Clk);
      end
    end
    if (!done) check_val("done_reached", 1'b0, 1'b1);
    check_val("valid_cycles", n_valid, r);
    check_val("accepts", n_acc, 1);
    check_val("error_pulses", n_err, tmo);
    model_read = exp_read;
    n_txn++;
    $display("txn %0d %s addr=%08h be=%h rdel=%0d sdel=%0d timeout=%0d stall=%0d read=%08h",
             n_txn, st ? "store" : "load ", addr, exp_be, rdel, sdel, tmo, n_stall, Data_Mem_Read);
  endtask

  // Idle cycle with a stray response on the bus; nothing may react to it.
  task automatic idle_cycle(input logic [31:0] stray);
    @(negedge Clk);
    Load_Req = 1'b0;
    Data_Mem_Write_Ctrl = 4'h0;
    Bus_Ready = 1'b0;
    Bus_Resp_Valid = 1'b1;
    Bus_Rdata = stray;
    #1;
    check_val("idle_stall", Mem_Stall, 1'b0);
    check_val("idle_valid", Bus_Valid, 1'b0);
    check_val("idle_error", Mem_Error, 1'b0);
    check_val("idle_read", Data_Mem_Read, model_read);
  endtask

  initial begin
    Reset = 1'b1;
    Mem_Addr = '0; Load_Req = 1'b0; Data_Mem_Write_Ctrl = '0; Data_Mem_Write_Out = '0;
    Bus_Ready = 1'b0; Bus_Resp_Valid = 1'b0; Bus_Rdata = '0;
    model_read = 32'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_val("rst_valid", Bus_Valid, 1'b0);
    check_val("rst_stall", Mem_Stall, 1'b0);
    check_val("rst_error", Mem_Error, 1'b0);
    check_val("rst_read", Data_Mem_Read, 32'h0);
    check_val("rst_addr", Bus_Addr, 30'h0);
    check_val("rst_be", Bus_Byte_En, 4'h0);

    do_access(1'b1, 4'h0, 32'h0000_1008, 32'h0, 0, 0, 32'hDEAD_BEEF);
    do_access(1'b0, 4'b1100, 32'h0000_2000, 32'hABCD_0000, 3, 0, 32'h5555_5555);
    idle_cycle(32'h0BAD_0BAD);
    do_access(1'b1, 4'h0, 32'h0000_3004, 32'h0, 0, 20, 32'h1111_2222);
    idle_cycle(32'h1234_5678);
    idle_cycle(32'h0);
    do_access(1'b1, 4'h0, 32'h0000_4010, 32'h0, 1, 1, 32'hA5A5_0001);
    do_access(1'b0, 4'b0011, 32'h0000_4014, 32'h0000_BEEF, 0, 2, 32'h0);
    do_access(1'b1, 4'b0001, 32'h0000_5001, 32'h0000_00EE, 0, 0, 32'h0);
    do_access(1'b1, 4'h0, 32'h0000_6000, 32'h0, 2, 4, 32'h600D_CAFE);
    do_access(1'b1, 4'h0, 32'h0000_6004, 32'h0, 3, 4, 32'h0BAD_CAFE);
    do_access(1'b1, 4'h0, 32'h0000_7000, 32'h0, 0, 0, 32'h7777_1234);

    // Asynchronous reset in the middle of a WAIT phase.
    @(negedge Clk);
    Load_Req = 1'b1; Data_Mem_Write_Ctrl = 4'h0; Mem_Addr = 32'h40;
    Bus_Ready = 1'b0; Bus_Resp_Valid = 1'b0;
    @(negedge Clk); #1;
    Bus_Ready = Bus_Valid;
    @(negedge Clk); #1;
    Bus_Ready = 1'b0;
    check_val("pre_rst_wait", {Bus_Valid, Mem_Stall}, 2'b01);
    #2 Reset = 1'b1;
    #1;
    check_val("mid_rst_valid", Bus_Valid, 1'b0);
    check_val("mid_rst_read", Data_Mem_Read, 32'h0);
    check_val("mid_rst_stall_req", Mem_Stall, 1'b1);
    Load_Req = 1'b0;
    #1;
    check_val("mid_rst_stall_noreq", Mem_Stall, 1'b0);
    @(negedge Clk);
    #3 Reset = 1'b0;
    Bus_Resp_Valid = 1'b1; Bus_Rdata = 32'hCAFE_F00D;
    model_read = 32'h0;
    @(negedge Clk); #1;
    check_val("post_rst_read", Data_Mem_Read, 32'h0);
    check_val("post_rst_stall", Mem_Stall, 1'b0);
    Bus_Resp_Valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      bit          st, ld;
      logic [3:0]  wc;
      st = 1'($urandom_range(0, 1));
      wc = st ? 4'($urandom_range(1, 15)) : 4'h0;
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      do_access(ld, wc, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
